// File: rtl/ram_arb_pkg.sv
// Shared constants for the data-RAM port arbiter.
package ram_arb_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 32;

    // Port identifiers as carried through the read-response pipeline
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    // Lock ownership; OWN_NONE means neither port holds the RAM
    typedef enum logic [1:0] {
        OWN_CORE = 2'd0,
        OWN_LOAD = 2'd1,
        OWN_NONE = 2'd2
    } owner_e;

    localparam owner_e NO_OWNER = OWN_NONE;

    // Map a port id onto its lock-owner encoding
    function automatic owner_e owner_of(input logic port);
        return (port == PORT_LOAD) ? OWN_LOAD : OWN_CORE;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rsp_pipe.sv
// Read-response tracker: DEPTH-deep {valid, port id} shift register.
module rsp_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);

    logic vld_q [DEPTH];
    logic id_q  [DEPTH];

    // Shift each granted read toward the tail; reset drops everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                vld_q[i] <= 1'b0;
                id_q[i]  <= 1'b0;
            end
        end else begin
            vld_q[0] <= in_valid;
            id_q[0]  <= in_id;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of the single-port data RAM, with lock support.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_valid,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ready,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_valid,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ready,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    output logic          ram_rden,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    owner_e        lock_owner, lock_owner_d;
    logic          rr_ptr, rr_ptr_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    logic          gnt0, gnt1, gnt_any;
    logic          win_sel, win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          rsp_valid, rsp_id;

    // Arbiter state plus last-driven address/data so the RAM bus stays quiet when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_owner <= NO_OWNER;
            rr_ptr     <= PORT_CORE;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            lock_owner <= lock_owner_d;
            rr_ptr     <= rr_ptr_d;
            if (gnt_any) begin
                addr_q <= win_addr;
                data_q <= win_wdata;
            end
        end
    end

    // Grant selection, round-robin pointer and lock ownership update
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        rr_ptr_d     = rr_ptr;
        lock_owner_d = lock_owner;
        if (rst_n) begin
            case (lock_owner)
                OWN_CORE: gnt0 = p0_valid;
                OWN_LOAD: gnt1 = p1_valid;
                default: begin
                    if (p0_valid && p1_valid) begin
                        if (FIXED_PRIO != 0) begin
                            gnt0 = 1'b1;
                        end else begin
                            gnt0     = (rr_ptr == PORT_CORE);
                            gnt1     = (rr_ptr == PORT_LOAD);
                            rr_ptr_d = ~rr_ptr;
                        end
                    end else begin
                        gnt0 = p0_valid;
                        gnt1 = p1_valid;
                    end
                end
            endcase

            if (gnt0) begin
                if (p0_lock) begin
                    lock_owner_d = owner_of(PORT_CORE);
                end else if (lock_owner == OWN_CORE) begin
                    lock_owner_d = NO_OWNER;
                end
            end
            if (gnt1) begin
                if (p1_lock) begin
                    lock_owner_d = owner_of(PORT_LOAD);
                end else if (lock_owner == OWN_LOAD) begin
                    lock_owner_d = NO_OWNER;
                end
            end
        end
    end

    // Winner mux onto the RAM; enables only pulse on a grant
    always_comb begin
        gnt_any     = gnt0 | gnt1;
        win_sel     = gnt1;
        win_we      = win_sel ? p1_we    : p0_we;
        win_addr    = win_sel ? p1_addr  : p0_addr;
        win_wdata   = win_sel ? p1_wdata : p0_wdata;
        ram_address = gnt_any ? win_addr  : addr_q;
        ram_data    = gnt_any ? win_wdata : data_q;
        ram_wren    = gnt_any &  win_we;
        ram_rden    = gnt_any & ~win_we;
    end

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

    rsp_pipe #(
        .DEPTH (RD_LAT)
    ) u_rsp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (ram_rden),
        .in_id     (win_sel),
        .out_valid (rsp_valid),
        .out_id    (rsp_id)
    );

    assign p0_rvalid = rsp_valid && (rsp_id == PORT_CORE);
    assign p1_rvalid = rsp_valid && (rsp_id == PORT_LOAD);
    assign p0_rdata  = ram_q;
    assign p1_rdata  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_ram_port_arbiter;

    localparam int RD_LAT_M = 1;
    localparam int RD_LAT_F = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Round-robin DUT (RD_LAT = 1)
    logic        p0_valid, p0_we, p0_lock, p0_ready, p0_rvalid;
    logic [7:0]  p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_valid, p1_we, p1_lock, p1_ready, p1_rvalid;
    logic [7:0]  p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic [7:0]  ram_address;
    logic [31:0] ram_data, ram_q;
    logic        ram_rden, ram_wren;

    // Fixed-priority DUT (RD_LAT = 2)
    logic        f0_valid, f0_we, f0_lock, f0_ready, f0_rvalid;
    logic [7:0]  f0_addr;
    logic [31:0] f0_wdata, f0_rdata;
    logic        f1_valid, f1_we, f1_lock, f1_ready, f1_rvalid;
    logic [7:0]  f1_addr;
    logic [31:0] f1_wdata, f1_rdata;
    logic [7:0]  f_ram_address;
    logic [31:0] f_ram_data, f_ram_q, fq1;
    logic        f_ram_rden, f_ram_wren;

    ram_port_arbiter #(.AW(8), .DW(32), .RD_LAT(RD_LAT_M), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_rden(ram_rden),
        .ram_wren(ram_wren), .ram_q(ram_q)
    );

    ram_port_arbiter #(.AW(8), .DW(32), .RD_LAT(RD_LAT_F), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(f0_valid), .p0_we(f0_we), .p0_lock(f0_lock), .p0_addr(f0_addr),
        .p0_wdata(f0_wdata), .p0_ready(f0_ready), .p0_rvalid(f0_rvalid), .p0_rdata(f0_rdata),
        .p1_valid(f1_valid), .p1_we(f1_we), .p1_lock(f1_lock), .p1_addr(f1_addr),
        .p1_wdata(f1_wdata), .p1_ready(f1_ready), .p1_rvalid(f1_rvalid), .p1_rdata(f1_rdata),
        .ram_address(f_ram_address), .ram_data(f_ram_data), .ram_rden(f_ram_rden),
        .ram_wren(f_ram_wren), .ram_q(f_ram_q)
    );

    // Power-on RAM contents; 0x10 holds the single-read test word
    function automatic logic [31:0] init_word(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return (32'(a) * 32'h01000193) ^ 32'hA5C30F17;
    endfunction

    // Behavioural single-port RAM, one-cycle registered read
    logic [31:0] mem [256];
    bit          written [256];
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_address]     <= ram_data;
            written[ram_address] <= 1'b1;
        end
        if (ram_rden) ram_q <= written[ram_address] ? mem[ram_address] : init_word(ram_address);
    end

    // Read-only RAM for the fixed-priority DUT, two-cycle read latency
    always @(posedge clk) begin
        if (f_ram_rden) fq1 <= {4{f_ram_address}};
        f_ram_q <= fq1;
    end

    // Reference model: lock owner (-1 none), preferred port, expected data, response queue
    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } rsp_t;

    int          owner, pref, cyc;
    logic [31:0] shadow [256];
    rsp_t        rq [$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        last_ready0, last_ready1, last_rv0, last_rv1;
    logic [31:0] last_rd;
    logic        g_rec [5];
    int          n1;
    bit          e_r0 [6] = '{1, 1, 1, 0, 0, 0};
    bit          e_r1 [6] = '{0, 0, 0, 1, 0, 0};
    bit          e_v0 [6] = '{0, 0, 1, 1, 1, 0};
    bit          e_v1 [6] = '{0, 0, 0, 0, 0, 1};
    logic [31:0] e_d  [6] = '{0, 0, 32'h30303030, 32'h31313131, 32'h32323232, 32'h77777777};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the round-robin DUT checked against the model
    task automatic tick();
        int          w;
        logic        we_w, lk_w;
        logic [7:0]  a_w;
        logic [31:0] d_w;
        bit          rv0, rv1;
        logic [31:0] erd;
        rsp_t        r;
        @(negedge clk);
        w = -1;
        if (owner >= 0) begin
            if ((owner == 0 && p0_valid) || (owner == 1 && p1_valid)) w = owner;
        end else if (p0_valid && p1_valid) w = pref;
        else if (p0_valid) w = 0;
        else if (p1_valid) w = 1;
        we_w = (w == 1) ? p1_we    : p0_we;
        lk_w = (w == 1) ? p1_lock  : p0_lock;
        a_w  = (w == 1) ? p1_addr  : p0_addr;
        d_w  = (w == 1) ? p1_wdata : p0_wdata;

        chk("p0_ready", 32'(p0_ready), 32'(w == 0));
        chk("p1_ready", 32'(p1_ready), 32'(w == 1));
        chk("ram_rden", 32'(ram_rden), 32'(w >= 0 && !we_w));
        chk("ram_wren", 32'(ram_wren), 32'(w >= 0 && we_w));
        if (w >= 0) chk("ram_address", 32'(ram_address), 32'(a_w));
        if (w >= 0 && we_w) chk("ram_data", ram_data, d_w);

        rv0 = 1'b0; rv1 = 1'b0; erd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.port == 0) rv0 = 1'b1; else rv1 = 1'b1;
            erd = r.data;
        end
        chk("p0_rvalid", 32'(p0_rvalid), 32'(rv0));
        chk("p1_rvalid", 32'(p1_rvalid), 32'(rv1));
        if (rv0) chk("p0_rdata", p0_rdata, erd);
        if (rv1) chk("p1_rdata", p1_rdata, erd);

        last_ready0 = p0_ready; last_ready1 = p1_ready;
        last_rv0 = p0_rvalid;   last_rv1 = p1_rvalid;
        last_rd = p1_rvalid ? p1_rdata : p0_rdata;

        if (w >= 0) begin
            if (owner < 0 && p0_valid && p1_valid) pref = 1 - w;
            if (we_w) shadow[a_w] = d_w;
            else rq.push_back('{cyc + RD_LAT_M, w, shadow[a_w]});
            if (lk_w) owner = w;
            else if (owner == w) owner = -1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Everything quiet while reset is held
    task automatic rst_checks(input string tag);
        @(negedge clk);
        chk({tag, "_rden"},   32'(ram_rden),  0);
        chk({tag, "_wren"},   32'(ram_wren),  0);
        chk({tag, "_ready0"}, 32'(p0_ready),  0);
        chk({tag, "_ready1"}, 32'(p1_ready),  0);
        chk({tag, "_rv0"},    32'(p0_rvalid), 0);
        chk({tag, "_rv1"},    32'(p1_rvalid), 0);
    endtask

    task automatic idle();
        p0_valid = 1'b0; p0_lock = 1'b0;
        p1_valid = 1'b0; p1_lock = 1'b0;
    endtask

    task automatic model_reset();
        owner = -1; pref = 0; rq.delete();
    endtask

    task automatic drive(input int port, input logic v, input logic we, input logic lk,
                         input logic [7:0] a, input logic [31:0] d);
        if (port == 0) begin
            p0_valid = v; p0_we = we; p0_lock = lk; p0_addr = a; p0_wdata = d;
        end else begin
            p1_valid = v; p1_we = we; p1_lock = lk; p1_addr = a; p1_wdata = d;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_word(8'(i));
        model_reset();
        cyc = 0;
        f0_valid = 0; f0_we = 0; f0_lock = 0; f0_addr = 0; f0_wdata = 0;
        f1_valid = 0; f1_we = 0; f1_lock = 0; f1_addr = 0; f1_wdata = 0;

        // Reset with both ports requesting: nothing may reach the RAM
        drive(0, 1'b1, 1'b1, 1'b0, 8'h40, 32'h11112222);
        drive(1, 1'b1, 1'b0, 1'b0, 8'h41, 32'h0);
        rst_checks("por");
        idle();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single read by port 1
        drive(1, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
        tick();
        chk("single_ready", 32'(last_ready1), 1);
        idle();
        tick();
        chk("single_rv1",   32'(last_rv1), 1);
        chk("single_rv0",   32'(last_rv0), 0);
        chk("single_rdata", last_rd, 32'hDEADBEEF);

        // Round-robin contention for four cycles
        drive(0, 1'b1, 1'b0, 1'b0, 8'h50, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 8'h60, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            g_rec[k] = last_ready1;
            if (last_ready0) p0_addr = p0_addr + 8'd1;
            if (last_ready1) p1_addr = p1_addr + 8'd1;
        end
        for (int k = 0; k < 4; k++) chk("rr_grant", 32'(g_rec[k]), 32'(k % 2));
        tick();
        chk("rr_ptr_end", 32'(last_ready0), 1);
        idle();
        tick();

        // Port 1 locks for a four-write burst while port 0 waits
        drive(1, 1'b1, 1'b1, 1'b1, 8'h20, 32'hC0DE0000);
        drive(0, 1'b1, 1'b0, 1'b0, 8'h20, 32'h0);
        n1 = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            g_rec[k] = last_ready0;
            if (last_ready1) begin
                n1++;
                if (n1 == 4) p1_valid = 1'b0;
                else drive(1, 1'b1, 1'b1, 1'(n1 < 3), 8'(8'h20 + n1), 32'hC0DE0000 + 32'(n1));
            end
        end
        for (int k = 0; k < 5; k++) chk("lock_p0_ready", 32'(g_rec[k]), 32'(k == 4));
        for (int j = 1; j <= 4; j++) begin
            if (j < 4) p0_addr = 8'(8'h20 + j);
            else p0_valid = 1'b0;
            tick();
            chk("lock_rb_rv", 32'(last_rv0), 1);
            chk("lock_rb_data", last_rd, 32'hC0DE0000 + 32'(j - 1));
        end

        // Write then read of the same word on consecutive cycles
        drive(0, 1'b1, 1'b1, 1'b0, 8'h03, 32'h5A5A5A5A);
        tick();
        idle();
        drive(1, 1'b1, 1'b0, 1'b0, 8'h03, 32'h0);
        tick();
        idle();
        tick();
        chk("wtr_rv",   32'(last_rv1), 1);
        chk("wtr_data", last_rd, 32'h5A5A5A5A);

        // Reset while a locked read is in flight; write during reset must not land
        drive(0, 1'b1, 1'b0, 1'b1, 8'h10, 32'h0);
        tick();
        rst_n = 1'b0;
        model_reset();
        drive(0, 1'b1, 1'b1, 1'b0, 8'h10, 32'h0BAD0BAD);
        drive(1, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
        rst_checks("mid1");
        rst_checks("mid2");
        idle();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
        tick();
        chk("post_rst_unlocked", 32'(last_ready1), 1);
        chk("post_rst_no_rv0",   32'(last_rv0), 0);
        idle();
        tick();
        chk("post_rst_data", last_rd, 32'hDEADBEEF);

        // Randomized traffic; requests held until accepted
        for (int k = 0; k < 400; k++) begin
            if (!p0_valid || last_ready0)
                drive(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)), $urandom);
            if (!p1_valid || last_ready1)
                drive(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)), $urandom);
            tick();
        end
        idle();
        tick();
        tick();
        chk("drain", 32'(rq.size()), 0);

        // Fixed priority with two-cycle read latency
        for (int c = 0; c < 6; c++) begin
            f0_valid = 1'(c < 3); f0_we = 1'b0; f0_addr = 8'(8'h30 + c);
            f1_valid = 1'(c < 4); f1_we = 1'b0; f1_addr = 8'h77;
            @(negedge clk);
            chk("fp_ready0", 32'(f0_ready),  32'(e_r0[c]));
            chk("fp_ready1", 32'(f1_ready),  32'(e_r1[c]));
            chk("fp_rv0",    32'(f0_rvalid), 32'(e_v0[c]));
            chk("fp_rv1",    32'(f1_rvalid), 32'(e_v1[c]));
            if (e_v0[c]) chk("fp_rdata0", f0_rdata, e_d[c]);
            if (e_v1[c]) chk("fp_rdata1", f1_rdata, e_d[c]);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
